ff_fifo_with_reg_status: RTL and testbench
==========================================

// Module: ff_fifo_with_reg_status
// PURPOSE
//  Synchronous single-clock FIFO, any depth (not only power of two), all status outputs registered.
//  Adds the following to the basic registered empty/full FIFO:
//   - occupancy count
//   - programmable almost_empty / almost_full
//   - sticky overflow / underflow error flags
//  Sits between stream producers and consumers where flag timing must come straight from flops.
// PARAMETERS
//  width     8   data word width, >= 1
//  depth     10  number of entries, >= 2, any integer
//  ae_level  2   almost_empty asserted when count <= ae_level (0 .. depth-1)
//  af_level  8   almost_full asserted when count >= af_level (1 .. depth)
// PORTS
//  clk           in   1                 rising-edge clock
//  rst_n         in   1                 asynchronous active-low reset
//  push          in   1                 write request
//  pop           in   1                 read request
//  write_data    in   width             data written on accepted push
//  read_data     out  width             head entry; combinational read of storage at rd_ptr
//  empty         out  1                 registered
//  full          out  1                 registered
//  almost_empty  out  1                 registered
//  almost_full   out  1                 registered
//  count         out  $clog2(depth+1)   registered occupancy
//  overflow      out  1                 sticky; set on rejected push
//  underflow     out  1                 sticky; set on rejected pop
//  clear_err     in   1                 synchronous clear of overflow/underflow
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - pointers = 0, count = 0
//   - empty = 1, almost_empty = 1, full = 0, almost_full = (af_level == 0 ? 1 : 0)
//   - overflow = 0, underflow = 0
//   - storage not reset
//  Reset mid-operation discards all contents; first push after release lands at index 0.
//  Acceptance:
//   - pop_ok  = pop & ~empty
//   - push_ok = push & (~full | pop_ok)
//   - push while empty with pop: push accepted, pop rejected (no bypass); underflow set
//   - push+pop while full: both accepted; count stays depth; write lands in the slot being freed
//  Pointers: wr_ptr / rd_ptr of width $clog2(depth); increment on *_ok; wrap depth-1 -> 0.
//  Count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
//  Next-state flags, all derived from count_next and registered (latency 1 cycle after the accepting edge):
//   - empty_d = count_next == 0
//   - full_d  = count_next == depth
//   - almost_empty_d = count_next <= ae_level
//   - almost_full_d  = count_next >= af_level
//  Comparisons are done at counter width with zero-extension; no truncation.
//  read_data:
//   - valid whenever empty == 0
//   - the new head is visible in the cycle after pop_ok
//   - undefined content while empty
//  Errors:
//   - overflow  <= 1 when push & ~push_ok
//   - underflow <= 1 when pop & ~pop_ok
//   - clear_err clears both; a set event in the same cycle wins over clear_err
//  Storage write on push_ok only, at wr_ptr.
//  Rejected ops do not change pointers, count or data.
// STRUCTURE
//  Package ff_fifo_pkg:
//   - function ptr_w(depth) = $clog2(depth) (minimum 1)
//   - function cnt_w(depth) = $clog2(depth+1)
//   - function next_ptr(ptr, depth) for wrap increment
//  Sub-module ff_fifo_wrap_ptr (param depth): enable-driven wrapping pointer; instantiated twice (wr, rd).
//  Elaboration check: af_level <= depth, ae_level < depth; otherwise $fatal.
// TESTING
//  (width=8, depth=10, ae_level=2, af_level=8 unless stated)
//  1. Fill 10 pushes 0x00..0x09
//     -> count 1..10; almost_full from count 8; full after 10th edge; 11th push rejects and sets overflow.
//  2. Drain 10 pops from full
//     -> read_data 0x00..0x09 in order; empty after 10th edge; extra pop sets underflow; clear_err clears it next cycle.
//  3. Wrap: interleave 25 push/pop pairs at count 5
//     -> data order preserved across the 9 -> 0 wrap; count stays 5; no flag toggles.
//  4. Simultaneous push+pop at full
//     -> count stays 10, full stays 1, overflow 0.
//     Simultaneous push+pop at empty
//     -> count 1, empty deasserts next cycle, underflow 1.
//  5. Assert rst_n low mid-stream at count 6, asynchronously between edges
//     -> outputs take reset values immediately; next push of 0xA5 is read back first.
//  6. Re-run with depth=16, af_level=16
//     -> almost_full and full assert on the same edge; full after 16 pushes.

Source files
------------

// File: rtl/ff_fifo_pkg.sv
// Shared sizing helpers for the registered-status FIFO and its pointer sub-module.
package ff_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wrapping increment so non-power-of-two depths skip the unused codes.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ff_fifo_wrap_ptr.sv
// Enable-driven pointer that wraps from depth-1 back to 0.
module ff_fifo_wrap_ptr
    import ff_fifo_pkg::*;
#(
    parameter int depth = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic [ptr_w(depth)-1:0] ptr
);

    localparam int PW = ptr_w(depth);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= PW'(next_ptr(int'(ptr), depth));
        end
    end

endmodule

// File: rtl/ff_fifo_with_reg_status.sv
// Single-clock FIFO of arbitrary depth; every status output comes straight from a flop,
// computed one cycle early from the next-state occupancy.
module ff_fifo_with_reg_status
    import ff_fifo_pkg::*;
#(
    parameter int width    = 8,
    parameter int depth    = 10,
    parameter int ae_level = 2,
    parameter int af_level = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [width-1:0]        write_data,
    output logic [width-1:0]        read_data,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [cnt_w(depth)-1:0] count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clear_err
);

    localparam int PW = ptr_w(depth);
    localparam int CW = cnt_w(depth);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AE_C    = CW'(ae_level);
    localparam logic [CW-1:0] AF_C    = CW'(af_level);
    localparam logic          AF_RST  = (af_level == 0);

    if (af_level > depth || ae_level >= depth || depth < 2 || width < 1) begin : g_param_check
        $fatal(1, "ff_fifo_with_reg_status: illegal depth/width/almost levels");
    end

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CW-1:0]    count_next;

    // A pop into an empty FIFO is refused even when a push arrives alongside it.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 1'b1;
        end
    end

    ff_fifo_wrap_ptr #(.depth(depth)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (push_ok),
        .ptr   (wr_ptr)
    );

    ff_fifo_wrap_ptr #(.depth(depth)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pop_ok),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= write_data;
        end
    end

    assign read_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= AF_RST;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
            // A new error event in the same cycle takes priority over the clear.
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ff_fifo_with_reg_status.sv
// Directed bench for ff_fifo_with_reg_status: depth-10 instance with a queue reference,
// plus a depth-16 instance where almost_full and full coincide.
module tb_ff_fifo_with_reg_status;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] write_data = '0;
    logic       clear_err = 1'b0;
    logic [7:0] read_data;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [3:0] count;

    logic       push16 = 1'b0;
    logic       pop16 = 1'b0;
    logic [7:0] write_data16 = '0;
    logic       clear_err16 = 1'b0;
    logic [7:0] read_data16;
    logic       empty16, full16, almost_empty16, almost_full16, overflow16, underflow16;
    logic [4:0] count16;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always #5 clk = ~clk;

    ff_fifo_with_reg_status #(.width(8), .depth(10), .ae_level(2), .af_level(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .pop          (pop),
        .write_data   (write_data),
        .read_data    (read_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clear_err    (clear_err)
    );

    ff_fifo_with_reg_status #(.width(8), .depth(16), .ae_level(2), .af_level(16)) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push16),
        .pop          (pop16),
        .write_data   (write_data16),
        .read_data    (read_data16),
        .empty        (empty16),
        .full         (full16),
        .almost_empty (almost_empty16),
        .almost_full  (almost_full16),
        .count        (count16),
        .overflow     (overflow16),
        .underflow    (underflow16),
        .clear_err    (clear_err16)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every status output of the depth-10 instance against the reference queue.
    task automatic check_status(input string tag);
        int n;
        n = q.size();
        check_value({tag, "_count"}, 32'(count), 32'(n));
        check_value({tag, "_empty"}, 32'(empty), 32'(n == 0));
        check_value({tag, "_full"}, 32'(full), 32'(n == 10));
        check_value({tag, "_ae"}, 32'(almost_empty), 32'(n <= 2));
        check_value({tag, "_af"}, 32'(almost_full), 32'(n >= 8));
        check_value({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check_value({tag, "_unf"}, 32'(underflow), 32'(m_unf));
        if (n != 0) check_value({tag, "_rdata"}, 32'(read_data), 32'(q[0]));
    endtask

    task automatic step(input logic p, input logic o, input logic [7:0] d, input logic clr);
        logic pop_ok, push_ok;
        @(negedge clk);
        push = p; pop = o; write_data = d; clear_err = clr;
        pop_ok  = o && (q.size() != 0);
        push_ok = p && ((q.size() < 10) || pop_ok);
        @(posedge clk);
        #1;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(d);
        if (p && !push_ok) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (o && !pop_ok) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        push = 1'b0; pop = 1'b0; clear_err = 1'b0;
    endtask

    task automatic step16(input logic p, input logic [7:0] d);
        @(negedge clk);
        push16 = p; write_data16 = d;
        @(posedge clk);
        #1;
        push16 = 1'b0;
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        #1;
        check_value("rst_count", 32'(count), 0);
        check_value("rst_empty", 32'(empty), 1);
        check_value("rst_ae", 32'(almost_empty), 1);
        check_value("rst_full", 32'(full), 0);
        check_value("rst_af", 32'(almost_full), 0);
        check_value("rst_ovf", 32'(overflow), 0);
        check_value("rst_unf", 32'(underflow), 0);

        // 1: fill
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            check_status($sformatf("fill%0d", i));
        end
        check_value("fill_full", 32'(full), 1);
        step(1'b1, 1'b0, 8'hEE, 1'b0);
        check_status("fill_extra");
        check_value("fill_ovf", 32'(overflow), 1);

        // 2: drain
        for (int i = 0; i < 10; i++) begin
            check_value($sformatf("drain_head%0d", i), 32'(read_data), 32'(i));
            step(1'b0, 1'b1, 8'h00, 1'b0);
            check_status($sformatf("drain%0d", i));
        end
        check_value("drain_empty", 32'(empty), 1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check_status("drain_extra");
        check_value("drain_unf", 32'(underflow), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_status("clear");
        check_value("clear_unf", 32'(underflow), 0);
        check_value("clear_ovf", 32'(overflow), 0);

        // 3: wrap at steady count 5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        for (int k = 0; k < 25; k++) begin
            step(1'b1, 1'b1, 8'(8'h20 + k), 1'b0);
            check_status($sformatf("wrap%0d", k));
        end
        check_value("wrap_count", 32'(count), 5);
        for (int i = 0; i < 5; i++) begin
            check_value($sformatf("wrap_tail%0d", i), 32'(read_data), 32'(8'h34 + i));
            step(1'b0, 1'b1, 8'h00, 1'b0);
        end
        check_status("wrap_done");

        // 4: push+pop at full, then at empty
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        check_status("pp_full");
        check_value("pp_full_count", 32'(count), 10);
        check_value("pp_full_ovf", 32'(overflow), 0);
        check_value("pp_full_head", 32'(read_data), 32'h41);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            check_status($sformatf("pp_drain%0d", i));
        end
        step(1'b1, 1'b1, 8'h88, 1'b0);
        check_status("pp_empty");
        check_value("pp_empty_count", 32'(count), 1);
        check_value("pp_empty_unf", 32'(underflow), 1);
        check_value("pp_empty_data", 32'(read_data), 32'h88);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check_status("pp_cleanup");

        // 5: async reset mid-stream at count 6
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
        check_value("pre_rst_count", 32'(count), 6);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_value("arst_count", 32'(count), 0);
        check_value("arst_empty", 32'(empty), 1);
        check_value("arst_ae", 32'(almost_empty), 1);
        check_value("arst_af", 32'(almost_full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        check_status("post_rst");
        check_value("post_rst_data", 32'(read_data), 32'hA5);

        // 6: depth 16, af_level 16
        for (int i = 0; i < 16; i++) begin
            step16(1'b1, 8'(i));
            check_value($sformatf("d16_count%0d", i), 32'(count16), 32'(i + 1));
            check_value($sformatf("d16_full%0d", i), 32'(full16), 32'(i == 15));
            check_value($sformatf("d16_af%0d", i), 32'(almost_full16), 32'(i == 15));
        end
        step16(1'b1, 8'hFF);
        check_value("d16_ovf", 32'(overflow16), 1);
        check_value("d16_count_hold", 32'(count16), 16);
        check_value("d16_head", 32'(read_data16), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
